// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: boot-time loader that streams a length-prefixed little-endian image into instruction memory
// and holds the core in reset until the image is complete. Define LOADER_CHECKSUM_EN to require an XOR trailer byte.
module imem_loader #(
    parameter int          DEPTH_WORDS    = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        reload,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , ST_CSUM = 3'd6
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif
    localparam logic [16:0] LP_DEPTH   = 17'(DEPTH_WORDS);
    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_count;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;
    logic [31:0] r_idle;
    logic        w_xfer;
    logic        w_csum_state;
    logic        w_idle_state;
    logic        w_timeout;
    logic        w_last_word;
    logic        w_reload;
    logic [16:0] w_len;
    logic [31:0] w_idle_next;

    // Handshake: a byte transfers on the rising CLK edge where byte_valid && byte_ready. byte_ready is decoded
    // from r_state alone, so a source may hold byte_valid high through WRITE stalls without losing data.
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    assign w_csum_state = (r_state == ST_CSUM);
`else
    assign w_csum_state = 1'b0;
`endif

    assign byte_ready   = (r_state == ST_LEN0) || (r_state == ST_LEN1) || (r_state == ST_DATA) || w_csum_state;
    assign w_xfer       = byte_valid && byte_ready;
    assign w_idle_state = (r_state == ST_LEN1) || (r_state == ST_DATA) || w_csum_state;
    assign w_idle_next  = r_idle + 32'd1;
    assign w_timeout    = (LP_TIMEOUT != 32'd0) && w_idle_state && !w_xfer && (w_idle_next >= LP_TIMEOUT);
    assign w_len        = {1'b0, byte_data, r_count[7:0]};
    assign w_last_word  = ((r_word_idx + 16'd1) == r_count);
    assign w_reload     = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_LEN0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LEN0: begin
                if (w_xfer) w_state_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_xfer) begin
                    if (w_len[15:0] == 16'd0)  w_state_next = ST_AFTER_PAYLOAD;
                    else if (w_len > LP_DEPTH) w_state_next = ST_ERR;
                    else                       w_state_next = ST_DATA;
                end else if (w_timeout) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    if (r_byte_idx == 2'd3) w_state_next = ST_WRITE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_WRITE: begin
                w_state_next = w_last_word ? ST_AFTER_PAYLOAD : ST_DATA;
            end
            ST_DONE, ST_ERR: begin
                if (reload) w_state_next = ST_LEN0;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_xfer)         w_state_next = (byte_data == r_xor) ? ST_DONE : ST_ERR;
                else if (w_timeout) w_state_next = ST_ERR;
            end
`endif
            default: w_state_next = ST_LEN0;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_idle     <= '0;
        end else begin
            r_idle <= (w_idle_state && !w_xfer) ? w_idle_next : 32'd0;
            case (r_state)
                ST_LEN0: begin
                    if (w_xfer) begin
                        r_count[7:0] <= byte_data;
                        r_word_idx   <= '0;
                        r_byte_idx   <= '0;
                    end
                end
                ST_LEN1: begin
                    if (w_xfer) r_count[15:8] <= byte_data;
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= byte_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                ST_WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                end
                ST_DONE, ST_ERR: begin
                    // Memory is left as-is on reload; only the loader's own bookkeeping restarts.
                    if (w_reload) begin
                        r_count    <= '0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_word     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_xor <= '0;
        end else if (w_reload || (r_state == ST_LEN0 && w_xfer)) begin
            r_xor <= '0;
        end else if (r_state == ST_DATA && w_xfer) begin
            r_xor <= r_xor ^ byte_data;
        end
    end
`endif

    assign imem_we     = (r_state == ST_WRITE);
    assign imem_addr   = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
    assign imem_wdata  = r_word;
    assign core_reset  = (r_state != ST_DONE);
    assign load_done   = (r_state == ST_DONE);
    assign load_error  = (r_state == ST_ERR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader: table-driven, hand-written and randomized checks of imem_loader against a stream-level model.
module tb_imem_loader;

    localparam int          DEPTH   = 256;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          TIMEOUT = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int LAT_N3 = CSUM_EN ? 18 : 17;

    logic        CLK;
    logic        reset;
    logic        reload;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [2:0]  dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;

    typedef struct {
        logic [15:0] n;
        int          gap_lo;
        int          gap_hi;
        logic        exp_done;
        logic        exp_err;
    } vec_t;
    vec_t vecs[7];

    imem_loader #(
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .reload     (reload),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected {addr, data}
    always @(negedge CLK) begin
        if (!reset && imem_we) begin
            check("ready_low_in_write", byte_ready, 1'b0);
            check("core_held_in_write", core_reset, 1'b1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("imem_write", {imem_addr, imem_wdata}, exp_w);
            end
        end
    end

    // Drivers
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        byte_valid = 1'b0;
        repeat (gap) @(negedge CLK);
        byte_valid = 1'b1;
        byte_data  = b;
        waited = 0;
        while (!byte_ready && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("byte_accepted", byte_ready, 1'b1);
        @(negedge CLK);
        byte_valid = 1'b0;
    endtask

    task automatic wait_status(input int budget);
        int k;
        k = 0;
        while (!(load_done || load_error) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("status_reached", load_done || load_error, 1'b1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
        check("reload_ready", byte_ready, 1'b1);
        check("reload_done", load_done, 1'b0);
        check("reload_err", load_error, 1'b0);
        check("reload_core_reset", core_reset, 1'b1);
    endtask

    task automatic check_reset_vals();
        check("rst_ready", byte_ready, 1'b1);
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_error, 1'b0);
        check("rst_state", dbg_state, 3'd0);
    endtask

    // Builds an image from the stream rules, queues expected writes, sends it and reports status and model verdict.
    task automatic load_image(input logic [15:0] n, input int gap_lo, input int gap_hi, input bit bad_csum,
                              output logic done_o, output logic err_o, output int lat_o,
                              output logic exp_done_o, output logic exp_err_o);
        logic [7:0]  s[$];
        logic [7:0]  x;
        logic [31:0] w;
        int          start;
        int          g;
        x = 8'h00;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (int'(n) <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                w = $urandom;
                for (int k = 0; k < 4; k++) begin
                    s.push_back(w[8*k +: 8]);
                    x ^= w[8*k +: 8];
                end
                exp_q.push_back({BASE + 32'(4 * i), w});
            end
            if (CSUM_EN) s.push_back(bad_csum ? (x ^ 8'($urandom_range(255, 1))) : x);
        end
        exp_err_o  = (int'(n) > DEPTH) || (CSUM_EN && bad_csum);
        exp_done_o = !exp_err_o;
        start = cyc;
        foreach (s[j]) begin
            g = (j == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
            send_byte(s[j], g);
        end
        wait_status(20);
        done_o = load_done;
        err_o  = load_error;
        lat_o  = cyc - start;
        check("writes_drained", exp_q.size(), 0);
    endtask

    logic [7:0] t1_bytes[10];
    logic       d, e, md, me;
    int         lat;

    initial begin
        reset      = 1'b1;
        reload     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        vecs[0] = '{16'd1,      0, 0, 1'b1, 1'b0};
        vecs[1] = '{16'd0,      0, 0, 1'b1, 1'b0};
        vecs[2] = '{16'd256,    0, 0, 1'b1, 1'b0};
        vecs[3] = '{16'd257,    0, 0, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF,   0, 0, 1'b0, 1'b1};
        vecs[5] = '{16'd5,      0, 3, 1'b1, 1'b0};
        vecs[6] = '{16'd4,      9, 9, 1'b1, 1'b0};
        t1_bytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

        repeat (2) @(negedge CLK);
        check_reset_vals();
        reset = 1'b0;
        @(negedge CLK);

        // Two-word program, core released one cycle after the last write
        exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
        exp_q.push_back({32'h0000_0004, 32'h0010_0593});
        foreach (t1_bytes[i]) send_byte(t1_bytes[i], 0);
        check("t1_we_last", imem_we, 1'b1);
        check("t1_core_held", core_reset, 1'b1);
        if (CSUM_EN) send_byte(8'h30, 0);
        else         @(negedge CLK);
        check("t1_done", load_done, 1'b1);
        check("t1_core_released", core_reset, 1'b0);
        check("t1_drained", exp_q.size(), 0);
        do_reload();

        // Oversized count rejected after the second header byte
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("ovf_err", load_error, 1'b1);
        check("ovf_core_reset", core_reset, 1'b1);
        check("ovf_done", load_done, 1'b0);
        check("ovf_ready", byte_ready, 1'b0);
        repeat (5) @(negedge CLK);
        check("ovf_err_hold", load_error, 1'b1);
        do_reload();

        // N=3 at full rate with valid held high: stalls in WRITE, latency 2 + 5*N (+1 trailer)
        load_image(16'd3, 0, 0, 1'b0, d, e, lat, md, me);
        check("n3_done", d, 1'b1);
        check("n3_latency", lat, LAT_N3);
        do_reload();

        // Timeout mid-word, no timeout in LEN0, timeout in LEN1
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        repeat (9) @(negedge CLK);
        check("to_not_yet", load_error, 1'b0);
        @(negedge CLK);
        check("to_fired", load_error, 1'b1);
        check("to_core_reset", core_reset, 1'b1);
        do_reload();
        repeat (1000) @(negedge CLK);
        check("len0_no_timeout_err", load_error, 1'b0);
        check("len0_no_timeout_ready", byte_ready, 1'b1);
        send_byte(8'h05, 0);
        repeat (10) @(negedge CLK);
        check("len1_timeout", load_error, 1'b1);
        do_reload();

        // Async reset mid-word, then a fresh single-word image
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge CLK);
        reset = 1'b0;
        exp_q.push_back({BASE, 32'hDEAD_BEEF});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        if (CSUM_EN) send_byte(8'h22, 0);
        wait_status(20);
        check("rst_reload_done", load_done, 1'b1);
        check("rst_reload_drained", exp_q.size(), 0);
        do_reload();

        // reload is ignored mid-load
        exp_q.push_back({BASE, 32'h4433_2211});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        if (CSUM_EN) send_byte(8'h44, 0);
        wait_status(20);
        check("reload_ignored_done", load_done, 1'b1);
        check("reload_ignored_drained", exp_q.size(), 0);
        do_reload();

`ifdef LOADER_CHECKSUM_EN
        // Wrong trailer: the word is still written, then the load fails
        exp_q.push_back({BASE, 32'h4433_2211});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h45, 0);
        check("csum_bad_err", load_error, 1'b1);
        check("csum_bad_core_reset", core_reset, 1'b1);
        check("csum_bad_drained", exp_q.size(), 0);
        do_reload();
`endif

        // Table of counts and gap patterns
        for (int v = 0; v < 7; v++) begin
            load_image(vecs[v].n, vecs[v].gap_lo, vecs[v].gap_hi, 1'b0, d, e, lat, md, me);
            check("tbl_done", d, vecs[v].exp_done);
            check("tbl_err", e, vecs[v].exp_err);
            check("tbl_core_reset", core_reset, !vecs[v].exp_done);
            do_reload();
        end

        // Randomized images against the stream model
        for (int r = 0; r < 30; r++) begin
            logic [15:0] n;
            int          sel;
            sel = int'($urandom_range(9, 0));
            if (sel == 0)      n = 16'd0;
            else if (sel == 1) n = 16'($urandom_range(65535, 257));
            else               n = 16'($urandom_range(6, 1));
            load_image(n, 0, int'($urandom_range(4, 0)), ($urandom_range(3, 0) == 0), d, e, lat, md, me);
            check("rnd_done", d, md);
            check("rnd_err", e, me);
            check("rnd_core_reset", core_reset, !md);
            do_reload();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader upstream of the single-cycle core and its instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory's write port.
- Holds the core in reset until the image is complete; releases it only on a good load.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in words; larger word counts are rejected.
BASE_ADDR, 32'h0000_0000, byte address of the first written word.
TIMEOUT_CYCLES, 100000, idle cycles allowed between accepted bytes mid-load; 0 disables the timeout.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
reload  input  1  single-cycle pulse; restarts loading from DONE or ERR.
byte_valid  input  1  source presents byte_data.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle; byte transfers when byte_valid && byte_ready at the CLK edge.
imem_we  output  1  instruction memory write strobe, one cycle per word.
imem_addr  output  32  write byte address = BASE_ADDR + 4*word_index.
imem_wdata  output  32  assembled word.
core_reset  output  1  reset to the processor core; high while not in DONE.
load_done  output  1  image loaded and accepted.
load_error  output  1  load aborted.

Behaviour:
- Reset values: state=LEN0, byte_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset=1, load_done=0, load_error=0. All counters and the assembly register clear to 0.
- All outputs decode from registered state only. There is no combinational path from any input to any output.
- Stream format:
  - 2 bytes: word count N, LSB first.
  - Then 4*N payload bytes, each word LSB first.
  - With LOADER_CHECKSUM_EN defined, 1 trailer byte follows the payload.
- States:
  - LEN0 (ready=1): on transfer, latch N[7:0] and go to LEN1.
  - LEN1 (ready=1): on transfer, latch N[15:8]. Then:
    - N==0: go to DONE (or CSUM when the feature is enabled).
    - N>DEPTH_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA (ready=1):
    - Byte k of the current word fills bits [8k+7:8k].
    - On the 4th byte, go to WRITE.
  - WRITE (ready=0):
    - Drive imem_we=1 for exactly one cycle with imem_addr and imem_wdata valid.
    - Increment word_index.
    - If word_index+1==N, go to DONE (or CSUM); otherwise return to DATA.
  - DONE (ready=0): core_reset=0, load_done=1. Core is released on the cycle after the final imem_we.
  - ERR (ready=0): core_reset=1, load_error=1.
- Latency: 1 cycle per accepted byte, plus 1 WRITE cycle per word. Minimum 5 cycles per word at full source rate.
- Backpressure: byte_ready deasserts only in WRITE, DONE and ERR. A source holding byte_valid high stalls during WRITE, and that byte transfers in the following DATA cycle.
- Timeout:
  - In LEN1, DATA or CSUM, an idle counter increments each cycle without a transfer and clears on each transfer.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to ERR.
  - LEN0 never times out.
- reload:
  - Sampled only in DONE or ERR; ignored in all other states.
  - Returns to LEN0, clears all counters, load_done and load_error.
  - Reasserts core_reset the next cycle.
  - Previously written memory contents are not cleared.
- An async reset mid-load aborts immediately to reset values. A partially written image remains in memory and is overwritten by the next load.
- word_index is 16 bits wide. imem_addr arithmetic is 32-bit with no wrap check beyond the DEPTH_WORDS limit.

Optional Feature:
Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is maintained.
  - After the last WRITE (or after LEN1 when N==0), enter CSUM (ready=1) and accept one byte.
  - Byte equals the XOR: go to DONE. Byte differs: go to ERR.
  - For N==0 the expected checksum is 8'h00.
- Not defined: CSUM state and XOR register are absent, and the loader goes directly to DONE.

Test Plan:
1. Reset, then stream 02 00 | 13 05 A0 00 | 93 05 10 00 at full rate. Required:
   - imem_we pulses at addr 0x0 with data 0x00A00513, then at 0x4 with 0x00100593.
   - load_done=1 and core_reset=0 one cycle after the second write.
2. Count 0x0101 (257) with DEPTH_WORDS=256 → ERR after the 2nd byte: load_error=1, core_reset=1, no imem_we. A reload pulse then returns to LEN0 with load_error=0.
3. byte_valid held high continuously with N=3 → byte_ready=0 in each WRITE cycle, no byte lost, words written at 0x0, 0x4, 0x8 in order.
4. TIMEOUT_CYCLES=10; send 02 00 AA, then idle 10 cycles → ERR on the 10th idle cycle. Separately, idle 1000 cycles in LEN0 → no error.
5. Assert reset mid-word (after 2 payload bytes) → outputs at reset values immediately. A fresh stream 01 00 EF BE AD DE then writes 0xDEADBEEF at BASE_ADDR.
6. With LOADER_CHECKSUM_EN: stream 01 00 11 22 33 44 then trailer 0x44 → DONE. Same stream with trailer 0x45 → ERR after the write at 0x0.
